truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Parametrised, synthesizable exhaustive-stimulus checker for combinational logic. After `start`, it drives every input pattern `0 … 2**N_IN-1` onto `pattern` in ascending order. It waits `SETTLE` cycles per pattern, samples the DUT output `y_in`, and compares it against the expected truth table `EXPECT`. It reports a pass/fail verdict, the mismatch count and the first failing pattern. It sits between the on-board start button/LEDs and any N-input combinational block under test.

## Interface
- `N_IN`, 3: number of DUT inputs; legal range 1–8.
- `SETTLE`, 2: cycles a pattern is held before sampling; must be ≥ 1.
- `EXPECT`, 8'hE8: expected output per pattern, width `2**N_IN`; bit `p` = expected `y_in` for `pattern == p`. The default is the 3-input majority function.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begins a sweep when sampled high in IDLE; ignored otherwise.
- `y_in` input 1: DUT output.
- `pattern` output N_IN: stimulus to the DUT; bit `N_IN-1` is the MSB (A in the 3-input case).
- `busy` output 1: high from the cycle after `start` until the cycle before `done`.
- `done` output 1: one-cycle pulse at the end of a sweep.
- `pass` output 1: registered verdict; `err_cnt == 0`; valid from `done`, held until the next accepted `start`.
- `err_cnt` output N_IN+1: number of mismatching patterns; saturation is never needed.
- `first_fail` output N_IN: lowest pattern that mismatched.
- `first_fail_vld` output 1: `first_fail` is meaningful.

## Operation
- States:
  - IDLE → SETTLE on `start`.
  - SETTLE → CHECK when the settle counter reaches `SETTLE-1`.
  - CHECK → SETTLE (`pattern+1`) if `pattern != 2**N_IN-1`, else → DONE.
  - DONE → IDLE unconditionally.
- On an accepted `start`, in the same edge:
  - `pattern`, settle counter, `err_cnt` ← 0
  - `first_fail_vld`, `pass` ← 0
  - `busy` ← 1
- CHECK compares `y_in` with `EXPECT[pattern]`. On a mismatch:
  - `err_cnt` increments.
  - If `first_fail_vld` is 0, `first_fail` ← `pattern` and `first_fail_vld` ← 1.
- `pattern` changes only on the edge leaving CHECK, so it is stable for exactly `SETTLE+1` cycles.
- DONE: `done` = 1, `busy` = 0, `pass` ← (`err_cnt` after the final CHECK update == 0).
- `start` held high through DONE starts a new sweep from IDLE one cycle later. It is not accepted in DONE itself.
- `pattern` keeps its last value (`2**N_IN-1`) after a sweep until the next `start`.
- Reset, including mid-sweep, forces all of the following to 0 immediately: every output, the settle counter, and the state (IDLE). The in-progress result is discarded.

## Timing
- `start` sampled at edge k.
- Pattern p is driven from cycle `k+1+p*(SETTLE+1)`.
- p is sampled in the CHECK cycle `k+(p+1)*(SETTLE+1)`.
- `done` is high in cycle `k+2**N_IN*(SETTLE+1)+1`.
- With defaults: 3 cycles per pattern; `done` at k+25.
- `y_in` must settle within `SETTLE` cycles of a `pattern` change. No combinational path exists from `y_in` to any output.
- Reset values: `pattern` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_cnt` = 0, `first_fail` = 0, `first_fail_vld` = 0.

## Structure
- Shared package `tt_sweep_pkg`:
  - state encoding localparams (IDLE, SETTLE, CHECK, DONE)
  - `clog2`-style width helper for the settle counter
- One sub-module, `tt_settle_timer`:
  - a load/count/terminal-count counter of width `clog2(SETTLE)`
  - reused by later sweep blocks
- Everything else stays in the top module.

## Test plan
- Defaults, correct majority DUT in the bench: pulse `start` → `done` at k+25, `pass` = 1, `err_cnt` = 0, `first_fail_vld` = 0. `pattern` walks 0→7, each value held 3 cycles.
- Defaults, DUT with output stuck at 0: `err_cnt` = 4, `first_fail` = 3'b011, `first_fail_vld` = 1, `pass` = 0.
- `N_IN` = 1, `SETTLE` = 1, `EXPECT` = 2'b10, inverted DUT: `err_cnt` = 2, `first_fail` = 0, `done` at k+5.
- Reset asserted during pattern 4 of a default sweep → all outputs 0 asynchronously. A fresh `start` after reset completes normally with `pass` = 1.
- `start` pulsed repeatedly while `busy` → ignored, `done` timing unchanged. `start` held high across DONE → second sweep begins with `busy` high 2 cycles after `done`, and `pass` is cleared on that accept.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep blocks: state encoding and
// the width helper that sizes the per-pattern settle counter.
package tt_sweep_pkg;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SETTLE_ENC = 2'd1;
  localparam logic [1:0] ST_CHECK_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SETTLE = ST_SETTLE_ENC,
    ST_CHECK  = ST_CHECK_ENC,
    ST_DONE   = ST_DONE_ENC
  } sweep_state_e;

  // Bits needed to count 0..cycles-1; never less than one bit.
  function automatic int settle_cnt_w(input int cycles);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < cycles) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Load/count counter that flags when it has reached a fixed terminal value;
// times how long each stimulus pattern is held before sampling.
module tt_settle_timer #(
  parameter int          W        = 1,
  parameter int unsigned TERMINAL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TC_VAL = W'(TERMINAL);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive-stimulus checker: walks every input pattern, samples the block
// under test after a settle time and compares against an expected truth table.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int                 N_IN   = 3,
  parameter int                 SETTLE = 2,
  parameter logic [2**N_IN-1:0] EXPECT = 8'hE8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            y_in,
  output logic [N_IN-1:0] pattern,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld
);

  localparam int              CNT_W    = settle_cnt_w(SETTLE);
  localparam logic [N_IN-1:0] LAST_PAT = {N_IN{1'b1}};

  sweep_state_e state, state_nxt;

  logic            accept;
  logic            check_cyc;
  logic            last_pat;
  logic            mismatch;
  logic            settle_tc;
  logic [N_IN:0]   err_nxt;

  assign accept    = (state == ST_IDLE) && start;
  assign check_cyc = (state == ST_CHECK);
  assign last_pat  = (pattern == LAST_PAT);
  assign mismatch  = check_cyc && (y_in != EXPECT[pattern]);
  assign err_nxt   = err_cnt + {{N_IN{1'b0}}, mismatch};

  // Counter is held at zero outside SETTLE, so every pattern starts a fresh count.
  tt_settle_timer #(
    .W       (CNT_W),
    .TERMINAL(SETTLE - 1)
  ) u_settle_timer (
    .clk (clk),
    .rst (rst),
    .load(state != ST_SETTLE),
    .en  (state == ST_SETTLE),
    .tc  (settle_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_tc) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = last_pat ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Status flags follow the state being entered, so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_SETTLE) || (state_nxt == ST_CHECK);
      done <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern        <= '0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else if (accept) begin
      pattern        <= '0;
      err_cnt        <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else if (check_cyc) begin
      err_cnt <= err_nxt;
      if (mismatch && !first_fail_vld) begin
        first_fail     <= pattern;
        first_fail_vld <= 1'b1;
      end
      // The verdict uses the count including this final comparison.
      if (last_pat) begin
        pass <= (err_nxt == '0);
      end else begin
        pattern <= pattern + N_IN'(1);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper: default 3-input instance and a
// 1-input instance, each driven by a table-described block under test.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start3 = 1'b0;
  logic start1 = 1'b0;
  logic [7:0] tbl3 = 8'hE8;
  logic [1:0] tbl1 = 2'b10;
  logic y3, y1;

  logic [2:0] pattern3, ff3;
  logic       busy3, done3, pass3, ffv3;
  logic [3:0] err3;
  logic [0:0] pattern1, ff1;
  logic       busy1, done1, pass1, ffv1;
  logic [1:0] err1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign y3 = tbl3[pattern3];
  assign y1 = tbl1[pattern1];

  truth_table_sweeper u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .y_in(y3),
    .pattern(pattern3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .first_fail(ff3), .first_fail_vld(ffv3)
  );

  truth_table_sweeper #(.N_IN(1), .SETTLE(1), .EXPECT(2'b10)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_in(y1),
    .pattern(pattern1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_fail(ff1), .first_fail_vld(ffv1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
  endtask

  function automatic logic [31:0] get_pat(input int which);
    return (which == 0) ? 32'(pattern3) : 32'(pattern1);
  endfunction
  function automatic logic [31:0] get_busy(input int which);
    return (which == 0) ? 32'(busy3) : 32'(busy1);
  endfunction
  function automatic logic [31:0] get_done(input int which);
    return (which == 0) ? 32'(done3) : 32'(done1);
  endfunction
  function automatic logic [31:0] get_pass(input int which);
    return (which == 0) ? 32'(pass3) : 32'(pass1);
  endfunction
  function automatic logic [31:0] get_err(input int which);
    return (which == 0) ? 32'(err3) : 32'(err1);
  endfunction
  function automatic logic [31:0] get_ff(input int which);
    return (which == 0) ? 32'(ff3) : 32'(ff1);
  endfunction
  function automatic logic [31:0] get_ffv(input int which);
    return (which == 0) ? 32'(ffv3) : 32'(ffv1);
  endfunction

  task automatic drive_start(input int which, input logic v);
    if (which == 0) start3 = v;
    else start1 = v;
  endtask

  task automatic check_reset_vals(input int which);
    check("rst_pattern", get_pat(which), 0);
    check("rst_busy", get_busy(which), 0);
    check("rst_done", get_done(which), 0);
    check("rst_pass", get_pass(which), 0);
    check("rst_err_cnt", get_err(which), 0);
    check("rst_first_fail", get_ff(which), 0);
    check("rst_first_fail_vld", get_ffv(which), 0);
  endtask

  // One full sweep; expectations come from the table and the timing formulas.
  task automatic run_sweep(input int which, input logic [7:0] tbl, input bit noisy, input bit hold);
    int npat, s, done_c, exp_err, exp_ff;
    logic [7:0] expv;
    if (which == 0) begin
      npat = 8; s = 2; expv = 8'hE8; tbl3 = tbl;
    end else begin
      npat = 2; s = 1; expv = 8'h02; tbl1 = tbl[1:0];
    end
    done_c  = npat * (s + 1) + 1;
    exp_err = 0;
    exp_ff  = -1;
    for (int p = 0; p < npat; p++) begin
      if (tbl[p] != expv[p]) begin
        exp_err++;
        if (exp_ff < 0) exp_ff = p;
      end
    end

    @(negedge clk);
    drive_start(which, 1'b1);
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      if (!hold) drive_start(which, noisy ? 1'($urandom_range(0, 1)) : 1'b0);
      check("busy", get_busy(which), 32'(c < done_c));
      check("done", get_done(which), 32'(c == done_c));
      if (c < done_c) check("pattern", get_pat(which), (c - 1) / (s + 1));
    end
    check("pass", get_pass(which), 32'(exp_err == 0));
    check("err_cnt", get_err(which), exp_err);
    check("first_fail_vld", get_ffv(which), 32'(exp_ff >= 0));
    if (exp_ff >= 0) check("first_fail", get_ff(which), exp_ff);

    @(negedge clk);
    if (!hold) drive_start(which, 1'b0);
    check("post_done", get_done(which), 0);
    check("post_busy", get_busy(which), 0);
    check("post_pattern", get_pat(which), npat - 1);
    check("post_pass", get_pass(which), 32'(exp_err == 0));

    @(negedge clk);
    if (hold) begin
      check("reaccept_busy", get_busy(which), 1);
      check("reaccept_pass", get_pass(which), 0);
      check("reaccept_err_cnt", get_err(which), 0);
      check("reaccept_pattern", get_pat(which), 0);
      drive_start(which, 1'b0);
      for (int c = 2; c <= done_c; c++) @(negedge clk);
      check("resweep_done", get_done(which), 1);
      check("resweep_pass", get_pass(which), 32'(exp_err == 0));
      @(negedge clk);
    end else begin
      check("idle_busy", get_busy(which), 0);
    end
  endtask

  task automatic mid_sweep_reset();
    tbl3 = 8'h00;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_pattern", pattern3, 4);
    check("mid_err_cnt", 32'(err3), 1);
    check("mid_first_fail_vld", 32'(ffv3), 1);
    #2 rst = 1'b1;
    #1 check_reset_vals(0);
    check_reset_vals(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_vals(0);
    check_reset_vals(1);
    @(negedge clk);
    rst = 1'b0;

    run_sweep(0, 8'hE8, 1'b0, 1'b0);
    run_sweep(0, 8'h00, 1'b0, 1'b0);
    run_sweep(1, 8'h01, 1'b0, 1'b0);
    mid_sweep_reset();
    run_sweep(0, 8'hE8, 1'b0, 1'b0);
    run_sweep(0, 8'hE8, 1'b1, 1'b0);
    run_sweep(0, 8'hE8, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) run_sweep(0, 8'($urandom), 1'(i), 1'b0);
    for (int i = 0; i < 3; i++) run_sweep(1, 8'($urandom_range(0, 3)), 1'(i), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
